core_run_ctrl: RTL

Run sequencer for the processor core. It takes a host start request and holds the core in `init` for a programmable number of cycles. It then issues a one-cycle `req`, waits for `ack`, and reports completion, cycle count and an optional watchdog fault. It sits between the testbench/host and the core's `init`/`req`/`ack` pins, and owns the core's reset and launch sequencing.

---
 rtl/core_run_ctrl_pkg.sv | 15 +
 rtl/core_run_ctrl_run_cycle_counter.sv | 38 +++
 rtl/core_run_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run sequencer: state encoding and default init length.
package Definitions;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        REQ   = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } run_state_t;

    localparam int DEF_INIT_CYCLES = 2;

endpackage

// File: rtl/core_run_ctrl_run_cycle_counter.sv
// Saturating run-length counter with clear/enable; at_limit feeds the watchdog
// compare when CORE_RUN_CTRL_WATCHDOG_EN is defined, otherwise it is tied low.
module run_cycle_counter #(
    parameter int CW    = 16,
    parameter int LIMIT = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    logic [CW-1:0] count_r;

    // Count up while enabled, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && (count_r != {CW{1'b1}})) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    assign at_limit = (count_r == CW'(LIMIT));
`else
    assign at_limit = 1'b0;
`endif

endmodule

// File: rtl/core_run_ctrl.sv
// Core run sequencer: init hold, one-cycle launch request, wait for ack, report.
// Optional watchdog fault path is compiled in with CORE_RUN_CTRL_WATCHDOG_EN.
module core_run_ctrl
    import Definitions::*;
#(
    parameter int INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int CW          = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          core_ack,
    output logic          core_init,
    output logic          core_req,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int             IW        = $clog2(INIT_CYCLES + 1);
    localparam logic [IW-1:0]  INIT_LOAD = IW'(INIT_CYCLES - 1);

    run_state_t    state_r;
    run_state_t    state_s;
    logic [IW-1:0] init_cnt_r;
    logic          at_limit_s;
    logic          expiry_s;
    logic          cnt_clr_s;
    logic          cnt_en_s;
    logic          core_init_s;
    logic          core_req_s;
    logic          busy_s;
    logic          done_s;
    logic          timeout_s;

    // Expiry freezes the count on the same edge that moves RUN into FAULT
    assign expiry_s  = (state_r == RUN) && at_limit_s;
    assign cnt_clr_s = (state_s == INIT) && (state_r != INIT);
    assign cnt_en_s  = ((state_r == REQ) || (state_r == RUN)) && !core_ack && !expiry_s;

    run_cycle_counter #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_cycle_counter (
        .clk      (Clk),
        .rst      (Reset),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .count    (cycles),
        .at_limit (at_limit_s)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ack takes priority over watchdog expiry
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = INIT;
                else       state_s = IDLE;
            end
            INIT: begin
                if (init_cnt_r == {IW{1'b0}}) state_s = REQ;
                else                          state_s = INIT;
            end
            REQ: begin
                state_s = RUN;
            end
            RUN: begin
                if (core_ack) state_s = DONE;
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
                else if (expiry_s) state_s = FAULT;
`endif
                else          state_s = RUN;
            end
            DONE: begin
                if (start) state_s = INIT;
                else       state_s = DONE;
            end
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
            FAULT: begin
                if (start) state_s = INIT;
                else       state_s = FAULT;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Init hold down-counter, loaded on every entry into INIT
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            init_cnt_r <= {IW{1'b0}};
        end else if (cnt_clr_s) begin
            init_cnt_r <= INIT_LOAD;
        end else if ((state_r == INIT) && (init_cnt_r != {IW{1'b0}})) begin
            init_cnt_r <= init_cnt_r - IW'(1'b1);
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Output decode of the upcoming state, so outputs land in registers
    always_comb begin
        core_init_s = 1'b1;
        core_req_s  = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_s)
            IDLE: begin
                core_init_s = 1'b1;
            end
            INIT: begin
                busy_s = 1'b1;
            end
            REQ: begin
                core_init_s = 1'b0;
                core_req_s  = 1'b1;
                busy_s      = 1'b1;
            end
            RUN: begin
                core_init_s = 1'b0;
                busy_s      = 1'b1;
            end
            DONE: begin
                core_init_s = 1'b0;
                done_s      = 1'b1;
            end
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
            FAULT: begin
                timeout_s = 1'b1;
            end
`endif
            default: begin
                core_init_s = 1'b1;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            core_init <= 1'b1;
            core_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            core_init <= core_init_s;
            core_req  <= core_req_s;
            busy      <= busy_s;
            done      <= done_s;
            timeout   <= timeout_s;
        end
    end

endmodule
